// File: rtl/jtag_unlock_ctrl.sv
// Debug-port unlock controller feeding the JTAG lock register; grant pulse appears one cycle after the check cycle.
// key_ready is high only in LOCKED, so attempts wait during check, unlocked session and lockout.
module jtag_unlock_ctrl #(
  parameter int               KEY_W          = 16,
  parameter logic [KEY_W-1:0] UNLOCK_KEY     = 16'hA5C3,
  parameter int               MAX_TRIES      = 3,
  parameter int               LOCKOUT_CYCLES = 64,
  parameter int               SESSION_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_valid,
  input  logic [KEY_W-1:0]                 key_data,
  output logic                             key_ready,
  input  logic                             relock_req,
  input  logic                             dbg_activity,
  output logic                             lock_en,
  output logic                             lock_value,
  output logic                             unlocked,
  output logic                             lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int FC_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IDLE_W = $clog2(SESSION_CYCLES + 2);
  localparam logic [FC_W-1:0]   FC_MAX    = FC_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(LOCKOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((SESSION_CYCLES == 0) ? 0 : SESSION_CYCLES - 1);
  localparam bit                SESSION_EN = (SESSION_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                lock_en_q, lock_en_d;
  logic                lock_value_q, lock_value_d;
  logic [FC_W-1:0]     fail_count_q, fail_count_d;
  logic [TMR_W-1:0]    lock_tmr_q, lock_tmr_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  logic                key_match;
  logic [FC_W-1:0]     fail_inc;
  logic                session_timeout;

  assign key_match       = (key_q == UNLOCK_KEY);
  assign fail_inc        = (fail_count_q == FC_MAX) ? fail_count_q : fail_count_q + 1'b1;
  assign session_timeout = SESSION_EN && (idle_q == IDLE_LAST) && !dbg_activity;

  // lock_en resets high so the downstream register loads "locked" on the first edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOCKED;
      key_q        <= '0;
      lock_en_q    <= 1'b1;
      lock_value_q <= 1'b0;
      fail_count_q <= '0;
      lock_tmr_q   <= '0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      lock_en_q    <= lock_en_d;
      lock_value_q <= lock_value_d;
      fail_count_q <= fail_count_d;
      lock_tmr_q   <= lock_tmr_d;
      idle_q       <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOCKED: begin
        if (key_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (relock_req)            state_d = ST_LOCKED;
        else if (key_match)        state_d = ST_UNLOCKED;
        else if (fail_inc == FC_MAX) state_d = ST_LOCKOUT;
        else                       state_d = ST_LOCKED;
      end
      ST_UNLOCKED: begin
        if (relock_req || session_timeout) state_d = ST_LOCKED;
      end
      ST_LOCKOUT: begin
        if (lock_tmr_q <= TMR_LAST) state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_comb begin
    key_d        = key_q;
    lock_en_d    = 1'b0;
    lock_value_d = lock_value_q;
    fail_count_d = fail_count_q;
    lock_tmr_d   = lock_tmr_q;
    idle_d       = idle_q;
    case (state_q)
      ST_LOCKED: begin
        if (key_valid) key_d = key_data;
      end
      ST_CHECK: begin
        idle_d    = '0;
        lock_en_d = 1'b1;
        if (relock_req) begin
          lock_value_d = 1'b0;
        end else if (key_match) begin
          lock_value_d = 1'b1;
          fail_count_d = '0;
        end else begin
          lock_value_d = 1'b0;
          fail_count_d = fail_inc;
          if (fail_inc == FC_MAX) lock_tmr_d = TMR_LOAD;
        end
      end
      ST_UNLOCKED: begin
        if (relock_req || session_timeout) begin
          lock_en_d    = 1'b1;
          lock_value_d = 1'b0;
          idle_d       = '0;
        end else if (dbg_activity) begin
          idle_d = '0;
        end else if (idle_q != '1) begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        // lock is already 0 here, so leaving lockout needs no pulse
        lock_tmr_d = lock_tmr_q - 1'b1;
        if (lock_tmr_q <= TMR_LAST) fail_count_d = '0;
      end
      default: ;
    endcase
  end

  assign key_ready  = (state_q == ST_LOCKED);
  assign unlocked   = (state_q == ST_UNLOCKED);
  assign lockout    = (state_q == ST_LOCKOUT);
  assign lock_en    = lock_en_q;
  assign lock_value = lock_value_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// Bench for jtag_unlock_ctrl: directed attempts checked against a cycle model and literal expectations.
module tb_jtag_unlock_ctrl;

  localparam logic [15:0] KEY = 16'hA5C3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [15:0] key_data = 16'h0000;
  logic        relock_req = 1'b0;
  logic        dbg_activity = 1'b0;
  logic        key_ready, lock_en, lock_value, unlocked, lockout;
  logic [1:0]  fail_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model of the controller's observable behaviour
  bit          m_open = 1'b0;
  bit          m_judging = 1'b0;
  int          m_frozen = 0;
  int          m_fails = 0;
  int          m_idle = 0;
  logic [15:0] m_key = 16'h0000;
  bit          m_en = 1'b1;
  bit          m_val = 1'b0;

  jtag_unlock_ctrl #(
    .KEY_W(16), .UNLOCK_KEY(KEY), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(64), .SESSION_CYCLES(256)
  ) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .relock_req(relock_req), .dbg_activity(dbg_activity),
    .lock_en(lock_en), .lock_value(lock_value),
    .unlocked(unlocked), .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 1'b0; m_judging = 1'b0; m_frozen = 0; m_fails = 0;
    m_idle = 0; m_key = 16'h0000; m_en = 1'b1; m_val = 1'b0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else begin
      m_en = 1'b0;
      if (m_judging) begin
        m_judging = 1'b0;
        m_en = 1'b1;
        if (relock_req) begin
          m_val = 1'b0;
        end else if (m_key == KEY) begin
          m_open = 1'b1; m_val = 1'b1; m_fails = 0; m_idle = 0;
        end else begin
          m_val = 1'b0;
          if (m_fails < 3) m_fails++;
          if (m_fails == 3) m_frozen = 64;
        end
      end else if (m_open) begin
        if (relock_req) begin
          m_open = 1'b0; m_en = 1'b1; m_val = 1'b0;
        end else if (dbg_activity) begin
          m_idle = 0;
        end else if (m_idle == 255) begin
          m_open = 1'b0; m_en = 1'b1; m_val = 1'b0;
        end else begin
          m_idle++;
        end
      end else if (m_frozen > 0) begin
        m_frozen--;
        if (m_frozen == 0) m_fails = 0;
      end else if (key_valid) begin
        m_judging = 1'b1;
        m_key = key_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic attempt(input logic [15:0] k);
    key_valid = 1'b1; key_data = k;
    tick();
    key_valid = 1'b0; key_data = ~k;
    tick();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("key_ready",  key_ready,  32'(!m_judging && !m_open && m_frozen == 0));
        check("unlocked",   unlocked,   32'(m_open));
        check("lockout",    lockout,    32'(m_frozen > 0));
        check("lock_en",    lock_en,    32'(m_en));
        check("lock_value", lock_value, 32'(m_val));
        check("fail_count", fail_count, 32'(m_fails));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_lock_en", lock_en, 1);
    check("rst_lock_value", lock_value, 0);
    check("rst_key_ready", key_ready, 1);
    check("rst_unlocked", unlocked, 0);
    check("rst_fail_count", fail_count, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_en_held", lock_en, 1);
    tick();
    @(negedge clk);
    check("post_rst_en_drop", lock_en, 0);

    // correct key: grant pulse then session open
    attempt(KEY);
    @(negedge clk);
    check("grant_en", lock_en, 1);
    check("grant_value", lock_value, 1);
    tick();
    check("grant_unlocked", unlocked, 1);
    check("grant_en_single", lock_en, 0);
    check("grant_fail_count", fail_count, 0);
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    check("relock_en", lock_en, 1);
    check("relock_value", lock_value, 0);
    check("relock_unlocked", unlocked, 0);

    // three failures then lockout; the right key and relock are ignored meanwhile
    for (int i = 1; i <= 3; i++) begin
      attempt(16'h0000);
      check("fail_count_step", fail_count, 32'(i));
    end
    check("lockout_entered", lockout, 1);
    key_valid = 1'b1; key_data = KEY; relock_req = 1'b1;
    n = 0;
    while (lockout === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    key_valid = 1'b0; relock_req = 1'b0;
    check("lockout_cycles", n, 64);
    check("lockout_exit_fail", fail_count, 0);
    check("lockout_exit_ready", key_ready, 1);
    check("lockout_exit_value", lock_value, 0);

    // idle session times out after 256 cycles
    attempt(KEY);
    n = 0;
    while (unlocked === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    check("session_cycles", n, 256);
    check("timeout_en", lock_en, 1);
    check("timeout_value", lock_value, 0);

    // periodic activity keeps the session open
    attempt(KEY);
    repeat (10) begin
      repeat (99) tick();
      dbg_activity = 1'b1; tick(); dbg_activity = 1'b0;
    end
    check("activity_keeps_open", unlocked, 1);
    repeat (255) tick();
    dbg_activity = 1'b1; tick(); dbg_activity = 1'b0;
    check("activity_at_timeout", unlocked, 1);
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    check("manual_relock", unlocked, 0);

    // relock during the check cycle discards a correct key
    attempt(16'h1234);
    check("one_fail", fail_count, 1);
    key_valid = 1'b1; key_data = KEY; tick();
    key_valid = 1'b0; relock_req = 1'b1; tick(); relock_req = 1'b0;
    check("chk_relock_unlocked", unlocked, 0);
    check("chk_relock_en", lock_en, 1);
    check("chk_relock_value", lock_value, 0);
    check("chk_relock_fail", fail_count, 1);
    check("chk_relock_ready", key_ready, 1);

    // reset in the middle of a lockout
    attempt(16'h0000);
    attempt(16'h0000);
    check("second_lockout", lockout, 1);
    repeat (34) tick();
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_lockout", lockout, 0);
    check("async_rst_fail", fail_count, 0);
    check("async_rst_en", lock_en, 1);
    check("async_rst_value", lock_value, 0);
    check("async_rst_ready", key_ready, 1);
    tick();
    reset = 1'b0;
    attempt(16'hFFFF);
    check("after_rst_fail", fail_count, 1);
    attempt(KEY);
    check("after_rst_unlocked", unlocked, 1);
    check("after_rst_fail_clear", fail_count, 0);
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    repeat (4) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
